// File: rtl/blink_stream_frontend.sv
// Streaming front end for the registered Blink cipher core: builds {nonce, counter} tweaks,
// tracks blocks through the fixed-latency core and buffers results in a credit-protected FIFO.
//
// state  | meaning
// IDLE   | waiting for start; no input accepted
// STREAM | accepting blocks while FIFO credit remains
// DRAIN  | last block accepted; waiting for pipe and FIFO to empty
module blink_stream_frontend #(
    parameter int N          = 64,
    parameter int TWEAK_LEN  = 128,
    parameter int CORE_LAT   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [N-1:0]         i_nonce,
    input  logic [N-1:0]         i_ctr_init,
    input  logic                 i_enc_cfg,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [N-1:0]         i_in_data,
    input  logic                 i_in_last,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [N-1:0]         o_out_data,
    output logic                 o_out_last,
    output logic                 o_core_enc,
    output logic [N-1:0]         o_core_p,
    output logic [TWEAK_LEN-1:0] o_core_t,
    input  logic [N-1:0]         i_core_c,
    output logic                 o_idle
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(CORE_LAT + 1);
    localparam int SW = ((CW > IW) ? CW : IW) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [N-1:0]        r_nonce;
    logic [N-1:0]        r_ctr;
    logic                r_core_enc;
    logic [CORE_LAT-1:0] r_tag_v;
    logic [CORE_LAT-1:0] r_tag_l;
    logic [N:0]          r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [IW-1:0]       w_inflight;
    logic                w_credit;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_fifo_empty;
    logic [N:0]          w_head;

    assign w_accept     = i_in_valid & o_in_ready;
    assign w_push       = r_tag_v[CORE_LAT-1];
    assign w_fifo_empty = (r_count == '0);
    assign w_pop        = ~w_fifo_empty & i_out_ready;
    assign w_head       = r_mem[r_rd_ptr];

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < CORE_LAT; i++) begin
            w_inflight = w_inflight + IW'(r_tag_v[i]);
        end
    end

    // Every accepted block owns a FIFO slot from acceptance until it is popped.
    assign w_credit = (SW'(r_count) + SW'(w_inflight)) < SW'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next_state = S_STREAM;
            end
            S_STREAM: begin
                if (w_accept && i_in_last) w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_fifo_empty && (w_inflight == '0) && !w_push) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_in_ready = 1'b0;
        o_idle     = 1'b0;
        case (r_state)
            S_IDLE:   o_idle     = w_fifo_empty && (w_inflight == '0);
            S_STREAM: o_in_ready = w_credit;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_nonce    <= '0;
            r_ctr      <= '0;
            r_core_enc <= 1'b0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_nonce    <= i_nonce;
            r_ctr      <= i_ctr_init;
            r_core_enc <= i_enc_cfg;
        end else if (w_accept) begin
            r_ctr <= r_ctr + N'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_v <= '0;
            r_tag_l <= '0;
        end else begin
            r_tag_v[0] <= w_accept;
            r_tag_l[0] <= w_accept & i_in_last;
            for (int i = 1; i < CORE_LAT; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_l[i] <= r_tag_l[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {i_core_c, r_tag_l[CORE_LAT-1]};
    end

    assign o_out_valid = ~w_fifo_empty;
    assign o_out_data  = w_fifo_empty ? '0 : w_head[N:1];
    assign o_out_last  = w_fifo_empty ? 1'b0 : w_head[0];
    assign o_core_enc  = r_core_enc;
    assign o_core_p    = i_in_data;
    assign o_core_t    = {r_nonce, r_ctr};

endmodule

// File: tb/tb_blink_stream_frontend.sv
// Scoreboard bench for blink_stream_frontend with a stand-in 2-cycle registered core.
module tb_blink_stream_frontend;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [63:0]  nonce;
    logic [63:0]  ctr_init;
    logic         enc_cfg;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic         out_last;
    logic         core_enc;
    logic [63:0]  core_p;
    logic [127:0] core_t;
    logic [63:0]  core_c;
    logic         idle;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int cyc   = 0;
    int last_acc_cyc = 0;

    logic [63:0] exp_nonce;
    logic [63:0] exp_ctr;
    logic        exp_enc;
    logic [64:0] exp_q[$];
    logic [64:0] mon_e;

    always #5 clk = ~clk;

    blink_stream_frontend dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .i_nonce     (nonce),
        .i_ctr_init  (ctr_init),
        .i_enc_cfg   (enc_cfg),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .i_in_last   (in_last),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_last  (out_last),
        .o_core_enc  (core_enc),
        .o_core_p    (core_p),
        .o_core_t    (core_t),
        .i_core_c    (core_c),
        .o_idle      (idle)
    );

    function automatic logic [63:0] core_f(input logic e, input logic [63:0] p, input logic [127:0] t);
        logic [63:0] x;
        x = p ^ t[63:0] ^ {t[120:64], t[127:121]};
        return e ? x : ({x[31:0], x[63:32]} ^ 64'h5A5A_C3C3_0F0F_9696);
    endfunction

    // Stand-in core: input register then output register, reset with the front end.
    logic         cm_enc;
    logic [63:0]  cm_p;
    logic [127:0] cm_t;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cm_enc <= 1'b0;
            cm_p   <= '0;
            cm_t   <= '0;
            core_c <= '0;
        end else begin
            cm_enc <= core_enc;
            cm_p   <= core_p;
            cm_t   <= core_t;
            core_c <= core_f(cm_enc, cm_p, cm_t);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got %h last %b with nothing expected", out_data, out_last);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", {64'h0, out_data}, {64'h0, mon_e[64:1]});
                    chk("out_last", {127'h0, out_last}, {127'h0, mon_e[0]});
                end
            end
        end
    end

    task automatic do_start(input logic [63:0] n, input logic [63:0] c, input logic e);
        @(posedge clk); #1;
        start = 1'b1; nonce = n; ctr_init = c; enc_cfg = e;
        @(posedge clk); #1;
        start = 1'b0;
        exp_nonce = n; exp_ctr = c; exp_enc = e;
        chk("core_enc", {127'h0, core_enc}, {127'h0, e});
    endtask

    task automatic send(input logic [63:0] d, input logic l);
        in_valid = 1'b1; in_data = d; in_last = l;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                chk("core_t", core_t, {exp_nonce, exp_ctr});
                exp_q.push_back({core_f(exp_enc, d, {exp_nonce, exp_ctr}), l});
                exp_ctr = exp_ctr + 64'd1;
                n_acc++;
                last_acc_cyc = cyc;
                @(posedge clk); #1;
                in_valid = 1'b0; in_last = 1'b0;
                return;
            end
        end
        n_vec++; n_err++;
        $display("FAIL send_timeout: block %h never accepted", d);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (idle && exp_q.size() == 0) return;
        end
        n_vec++; n_err++;
        $display("FAIL idle_timeout: idle=%b pending=%0d, required idle=1 pending=0", idle, exp_q.size());
    endtask

    int base_acc;
    int gap_bad;

    initial begin
        rst = 1'b0; start = 1'b0; nonce = '0; ctr_init = '0; enc_cfg = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        exp_nonce = '0; exp_ctr = '0; exp_enc = 1'b0;

        // 1: reset with random inputs, then in_valid in IDLE is ignored
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            start = 1'($urandom); nonce = {$urandom, $urandom}; ctr_init = {$urandom, $urandom};
            enc_cfg = 1'($urandom); in_valid = 1'($urandom); in_data = {$urandom, $urandom};
            in_last = 1'($urandom); out_ready = 1'($urandom);
        end
        #1;
        chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
        chk("rst_out_data", {64'h0, out_data}, 128'h0);
        chk("rst_out_last", {127'h0, out_last}, 128'h0);
        chk("rst_core_enc", {127'h0, core_enc}, 128'h0);
        chk("rst_idle", {127'h0, idle}, 128'h1);
        chk("rst_in_ready", {127'h0, in_ready}, 128'h0);
        chk("rst_core_t", core_t, 128'h0);
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1; in_data = 64'hFEED;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_in_ready", {127'h0, in_ready}, 128'h0);
        end
        in_valid = 1'b0;
        chk("idle_ctr_hold", core_t, 128'h0);

        // 2: single block, latency and return to idle
        do_start(64'h0123456789ABCDEF, 64'h0, 1'b1);
        send(64'h0, 1'b1);
        @(posedge clk); #1;
        chk("lat_e1_out_valid", {127'h0, out_valid}, 128'h0);
        @(posedge clk); #1;
        chk("lat_e2_out_valid", {127'h0, out_valid}, 128'h1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("idle_after_pop", {127'h0, idle}, 128'h1);
        out_ready = 1'b0;

        // 3: backpressure limits acceptance to FIFO_DEPTH, then everything drains in order
        do_start(64'hA5A5_0000_1111_2222, 64'h0, 1'b0);
        base_acc = n_acc;
        fork
            begin
                for (int i = 0; i < 10; i++) send(64'h1000 + 64'(i), (i == 9));
            end
            begin
                repeat (20) @(posedge clk);
                #2;
                chk("credit_accepts", 128'(n_acc - base_acc), 128'd4);
                chk("credit_in_ready", {127'h0, in_ready}, 128'h0);
                out_ready = 1'b1;
            end
        join
        wait_idle();
        chk("stream3_accepts", 128'(n_acc - base_acc), 128'd10);
        out_ready = 1'b0;

        // 4: counter wrap
        out_ready = 1'b1;
        do_start(64'hC0FF_EE00_BEEF_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        chk("wrap_ctr_first", {64'h0, core_t[63:0]}, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
        send(64'hDEAD_0001, 1'b0);
        chk("wrap_ctr_second", {64'h0, core_t[63:0]}, 128'h0);
        send(64'hDEAD_0002, 1'b1);
        wait_idle();

        // 5: sustained one block per cycle
        do_start(64'h5555_6666_7777_8888, 64'd100, 1'b1);
        gap_bad = 0;
        for (int i = 0; i < 12; i++) begin
            int prev;
            prev = last_acc_cyc;
            send(64'h9000 + 64'(i * 7), (i == 11));
            if (i > 0 && last_acc_cyc - prev != 1) gap_bad++;
        end
        chk("sustained_gaps", 128'(gap_bad), 128'd0);
        wait_idle();
        out_ready = 1'b0;

        // 6: start ignored mid-stream, then reset with blocks in flight
        do_start(64'h1234_0000_5678_0000, 64'd5, 1'b0);
        send(64'hAAAA, 1'b0);
        start = 1'b1; nonce = 64'hDEAD_BEEF_DEAD_BEEF; ctr_init = 64'd77;
        @(posedge clk); #1;
        start = 1'b0;
        send(64'hBBBB, 1'b0);
        send(64'hCCCC, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", {127'h0, out_valid}, 128'h0);
        chk("mid_rst_in_ready", {127'h0, in_ready}, 128'h0);
        chk("mid_rst_idle", {127'h0, idle}, 128'h1);
        chk("mid_rst_core_t", core_t, 128'h0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        do_start(64'h0F0F_1E1E_2D2D_3C3C, 64'h10, 1'b1);
        send(64'h7777, 1'b0);
        send(64'h8888, 1'b1);
        wait_idle();
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
